dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DM_ADDRESS, default 9, which is the byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, which is the data width.
REQ-003 The block SHALL have parameter WAIT_CYC, default 2, legal range 0..15, which is the number of wait states per access.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: responder can accept a request.
REQ-008 The block SHALL have port MemRead, input, 1 bit: the request is a load.
REQ-009 The block SHALL have port MemWrite, input, 1 bit: the request is a store.
REQ-010 The block SHALL have port addr, input, DM_ADDRESS bits: byte address.
REQ-011 The block SHALL have port wr_data, input, DATA_W bits: store data, right-aligned.
REQ-012 The block SHALL have port func3, input, 3 bits: RV32I load/store width code.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit: one-cycle response strobe.
REQ-014 The block SHALL have port rd_data, output, DATA_W bits: load result.
REQ-015 The block SHALL have port err, output, 1 bit: response error, valid with rsp_valid.
REQ-016 The block SHALL have port busy, output, 1 bit: an access is in progress.

Function
REQ-017 The storage array SHALL be 2^(DM_ADDRESS-2) little-endian 32-bit words, indexed by addr[DM_ADDRESS-1:2], with no reset of its contents.
REQ-018 The FSM SHALL have states IDLE, WAIT and RESP; req_ready=1 only in IDLE; busy=1 in any state other than IDLE.
REQ-019 A request SHALL be accepted on a rising edge with req_valid & req_ready & (MemRead | MemWrite); addr, func3, wr_data and the op SHALL be captured at that edge.
REQ-020 With req_valid=1 and MemRead=MemWrite=0, the block SHALL ignore the request and stay in IDLE.
REQ-021 After accept, the FSM SHALL go IDLE->WAIT when WAIT_CYC>0, or IDLE->RESP when WAIT_CYC=0; it SHALL stay WAIT_CYC cycles in WAIT using a down-counter, then go to RESP.
REQ-022 rsp_valid SHALL be high exactly during the RESP cycle, which is WAIT_CYC+1 cycles after the accept edge; RESP->IDLE is unconditional.
REQ-023 The next accept SHALL occur no earlier than the edge ending the cycle after RESP, i.e. one idle cycle with req_ready=1.
REQ-024 The store commit and the load sampling SHALL both occur on the edge entering RESP.
REQ-025 Loads: func3 000 = LB (sign-extend), 001 = LH (sign-extend), 010 = LW, 100 = LBU, 101 = LHU (zero-extend); the byte lane SHALL be addr[1:0] and the half lane addr[1].
REQ-026 Stores: func3 000 = SB, 001 = SH, 010 = SW; only the addressed lanes SHALL be written and the other bytes preserved.
REQ-027 The following SHALL give an error response: any other func3; a halfword access with addr[0]=1; a word access with addr[1:0]!=0; MemRead=MemWrite=1.
REQ-028 On an error response: err=1, rd_data=0, and no memory write.
REQ-029 A store response SHALL return rd_data=0 and err=0.
REQ-030 rd_data and err SHALL be registered and hold their value until the next RESP.

Reset
REQ-031 While reset is high: state=IDLE, wait counter=0, rsp_valid=0, err=0, rd_data=0, busy=0, and req_ready=0.
REQ-032 req_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-033 Reset asserted in WAIT SHALL abort the access: no store commit and no rsp_valid. A store already committed in RESP SHALL remain in memory.

Verification
REQ-034 WAIT_CYC=2: SW addr 0x010 data 0xDEADBEEF -> rsp_valid 3 cycles after accept with err=0; then LW 0x010 -> rd_data=0xDEADBEEF.
REQ-035 SB 0x80 to addr 0x011 -> LB 0x011 returns 0xFFFFFF80, LBU 0x011 returns 0x00000080, LW 0x010 returns 0xDEAD80EF.
REQ-036 LH 0x013 -> err=1 with rd_data=0; SW 0x012 -> err=1; a following LW 0x010 is still 0xDEAD80EF; MemRead=MemWrite=1 -> err=1; MemRead=MemWrite=0 -> no accept, busy stays 0.
REQ-037 req_valid held high for two back-to-back LWs -> the second accept occurs one cycle after the first rsp_valid; the rsp_valid pulses are exactly WAIT_CYC+2 cycles apart.
REQ-038 Reset pulsed during WAIT of SW 0x020 data 0x12345678 (prior value 0) -> no rsp_valid; req_ready=1 the cycle after reset; LW 0x020 returns 0x00000000.
REQ-039 WAIT_CYC=0 build: LW -> rsp_valid in the cycle after accept, and at most one accept every 2 cycles.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store master and the data-memory responder.
interface dmem_responder_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wr_data;
    logic [2:0]            func3;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rd_data;
    logic                  err;
    logic                  busy;

    modport master (
        output req_valid, MemRead, MemWrite, addr, wr_data, func3,
        input  req_ready, rsp_valid, rd_data, err, busy
    );

    modport slave (
        input  req_valid, MemRead, MemWrite, addr, wr_data, func3,
        output req_ready, rsp_valid, rd_data, err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data memory with RV32I byte/half/word loads and stores, one access at a time.
// The access (store commit or load sample) happens on the edge that enters RESP.
module dmem_responder #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int WAIT_CYC   = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << (DM_ADDRESS - 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic                  op_rd_reg, op_wr_reg;
    logic [DM_ADDRESS-1:0] addr_reg;
    logic [2:0]            func3_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [DATA_W-1:0]     rd_data_reg;
    logic                  err_reg;

    logic [31:0] mem [DEPTH];

    logic                  accept;
    logic                  enter_resp;
    logic                  eff_rd, eff_wr;
    logic [DM_ADDRESS-1:0] eff_addr;
    logic [2:0]            eff_f3;
    logic [DATA_W-1:0]     eff_wdata;
    logic                  acc_err;
    logic [31:0]           word_rd;
    logic [7:0]            byte_rd;
    logic [15:0]           half_rd;
    logic [31:0]           load_val;
    logic [31:0]           st_src;
    logic [31:0]           st_word;
    logic [3:0]            lane_hit;
    logic [3:0]            byte_we;
    logic                  store_ok;

    assign accept = bus.req_valid & (bus.MemRead | bus.MemWrite) &
                    (state_reg == IDLE) & ~reset;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYC == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_CYC);
                    end
                end
            end
            WAIT: begin
                if (cnt_reg <= 4'd1) begin
                    state_next = RESP;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RESP is always left after one cycle, so a RESP next-state means we are entering it.
    assign enter_resp = (state_next == RESP);

    // With no wait states the access completes on the accept edge, so use the live request.
    always_comb begin
        if (state_reg == IDLE) begin
            eff_rd    = bus.MemRead;
            eff_wr    = bus.MemWrite;
            eff_addr  = bus.addr;
            eff_f3    = bus.func3;
            eff_wdata = bus.wr_data;
        end else begin
            eff_rd    = op_rd_reg;
            eff_wr    = op_wr_reg;
            eff_addr  = addr_reg;
            eff_f3    = func3_reg;
            eff_wdata = wdata_reg;
        end
    end

    always_comb begin
        acc_err = 1'b0;
        if (eff_rd & eff_wr) begin
            acc_err = 1'b1;
        end else begin
            case (eff_f3)
                3'b000:         acc_err = 1'b0;
                3'b001:         acc_err = eff_addr[0];
                3'b010:         acc_err = |eff_addr[1:0];
                3'b100:         acc_err = eff_wr;
                3'b101:         acc_err = eff_wr | eff_addr[0];
                default:        acc_err = 1'b1;
            endcase
        end
    end

    assign word_rd = mem[eff_addr[DM_ADDRESS-1:2]];
    assign byte_rd = word_rd[{eff_addr[1:0], 3'b000} +: 8];
    assign half_rd = word_rd[{eff_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (eff_f3)
            3'b000:  load_val = {{24{byte_rd[7]}}, byte_rd};
            3'b001:  load_val = {{16{half_rd[15]}}, half_rd};
            3'b010:  load_val = word_rd;
            3'b100:  load_val = {24'd0, byte_rd};
            3'b101:  load_val = {16'd0, half_rd};
            default: load_val = 32'd0;
        endcase
    end

    // Store data is replicated across lanes; lane_hit picks which bytes are written.
    assign st_src   = 32'(eff_wdata);
    assign store_ok = eff_wr & ~eff_rd & ~acc_err;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign st_word[gi*8 +: 8] = (eff_f3[1:0] == 2'b00) ? st_src[7:0] :
                                        (eff_f3[1:0] == 2'b01) ? st_src[(gi%2)*8 +: 8] :
                                                                 st_src[gi*8 +: 8];
            assign lane_hit[gi] = (eff_f3[1:0] == 2'b00) ? (eff_addr[1:0] == 2'(gi)) :
                                  (eff_f3[1:0] == 2'b01) ? (eff_addr[1] == 1'(gi/2)) :
                                                           1'b1;
            assign byte_we[gi]  = lane_hit[gi] & store_ok;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset && enter_resp) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_we[i]) begin
                    mem[eff_addr[DM_ADDRESS-1:2]][i*8 +: 8] <= st_word[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            op_rd_reg   <= 1'b0;
            op_wr_reg   <= 1'b0;
            addr_reg    <= '0;
            func3_reg   <= 3'd0;
            wdata_reg   <= '0;
            rd_data_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                op_rd_reg <= bus.MemRead;
                op_wr_reg <= bus.MemWrite;
                addr_reg  <= bus.addr;
                func3_reg <= bus.func3;
                wdata_reg <= bus.wr_data;
            end
            if (enter_resp) begin
                err_reg     <= acc_err;
                rd_data_reg <= (!acc_err && eff_rd && !eff_wr) ? DATA_W'(load_val) : '0;
            end
        end
    end

    assign bus.req_ready = (state_reg == IDLE) & ~reset;
    assign bus.busy      = (state_reg != IDLE) & ~reset;
    assign bus.rsp_valid = (state_reg == RESP) & ~reset;
    assign bus.rd_data   = reset ? '0 : rd_data_reg;
    assign bus.err       = err_reg & ~reset;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, timing corner sequences, and random
// accesses against a byte-addressed reference memory.
module tb_dmem_responder;
    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();
    dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus0 ();

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYC(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYC(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [8:0]  addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[18];
    logic [7:0] mem_m [512];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Reference: byte-addressed memory, legality from access size and alignment.
    function automatic void model(input logic r, input logic w, input logic [8:0] a,
                                  input logic [2:0] f, input logic [31:0] d,
                                  output logic e, output logic [31:0] v);
        int size;
        e = 1'b0;
        v = 32'd0;
        size = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        if (r && w) e = 1'b1;
        else if (r && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e = 1'b1;
        else if (w && !(f inside {3'd0, 3'd1, 3'd2})) e = 1'b1;
        else if ((int'(a) % size) != 0) e = 1'b1;
        if (!e) begin
            if (r) begin
                for (int k = 0; k < size; k++) v = v | (32'(mem_m[int'(a) + k]) << (8 * k));
                if (!f[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFFFFFF << (8 * size));
            end else begin
                for (int k = 0; k < size; k++) mem_m[int'(a) + k] = d[8*k +: 8];
            end
        end
    endfunction

    task automatic issue(input logic r, input logic w, input logic [8:0] a,
                         input logic [2:0] f, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.MemRead   = r;
        bus.MemWrite  = w;
        bus.addr      = a;
        bus.func3     = f;
        bus.wr_data   = d;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) timeout("accept");
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic e, output logic [31:0] v, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 40);
        if (!bus.rsp_valid) begin
            timeout("rsp_valid");
            lat = -1;
        end
        e = bus.err;
        v = bus.rd_data;
        @(negedge clk);
        chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        chk("rd_data_hold", bus.rd_data, v);
        chk("err_hold", 32'(bus.err), 32'(e));
    endtask

    task automatic access(input logic r, input logic w, input logic [8:0] a,
                          input logic [2:0] f, input logic [31:0] d,
                          output logic e, output logic [31:0] v, output int lat);
        issue(r, w, a, f, d);
        wait_rsp(e, v, lat);
        $display("txn rd=%0d wr=%0d addr=%03h f3=%0d wd=%08h -> err=%0d rd_data=%08h lat=%0d",
                 r, w, a, f, d, e, v, lat);
    endtask

    initial begin
        logic        e, me;
        logic [31:0] v, mv;
        int          lat;
        int          acc_q[$];
        int          rsp_q[$];
        logic [31:0] dat_q[$];

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.req_valid = 0; bus.MemRead = 0; bus.MemWrite = 0;
        bus.addr = '0; bus.func3 = '0; bus.wr_data = '0;
        bus0.req_valid = 0; bus0.MemRead = 0; bus0.MemWrite = 0;
        bus0.addr = '0; bus0.func3 = '0; bus0.wr_data = '0;

        vt[0]  = '{1'b0, 1'b1, 9'h010, 3'b010, 32'hDEADBEEF, 1'b0, 32'h00000000};
        vt[1]  = '{1'b1, 1'b0, 9'h010, 3'b010, 32'h00000000, 1'b0, 32'hDEADBEEF};
        vt[2]  = '{1'b0, 1'b1, 9'h011, 3'b000, 32'h00000080, 1'b0, 32'h00000000};
        vt[3]  = '{1'b1, 1'b0, 9'h011, 3'b000, 32'h00000000, 1'b0, 32'hFFFFFF80};
        vt[4]  = '{1'b1, 1'b0, 9'h011, 3'b100, 32'h00000000, 1'b0, 32'h00000080};
        vt[5]  = '{1'b1, 1'b0, 9'h010, 3'b010, 32'h00000000, 1'b0, 32'hDEAD80EF};
        vt[6]  = '{1'b1, 1'b0, 9'h013, 3'b001, 32'h00000000, 1'b1, 32'h00000000};
        vt[7]  = '{1'b0, 1'b1, 9'h012, 3'b010, 32'h11111111, 1'b1, 32'h00000000};
        vt[8]  = '{1'b1, 1'b0, 9'h010, 3'b010, 32'h00000000, 1'b0, 32'hDEAD80EF};
        vt[9]  = '{1'b1, 1'b1, 9'h010, 3'b010, 32'h00000000, 1'b1, 32'h00000000};
        vt[10] = '{1'b1, 1'b0, 9'h012, 3'b001, 32'h00000000, 1'b0, 32'hFFFFDEAD};
        vt[11] = '{1'b1, 1'b0, 9'h012, 3'b101, 32'h00000000, 1'b0, 32'h0000DEAD};
        vt[12] = '{1'b0, 1'b1, 9'h012, 3'b001, 32'hABCDBEEF, 1'b0, 32'h00000000};
        vt[13] = '{1'b1, 1'b0, 9'h010, 3'b010, 32'h00000000, 1'b0, 32'hBEEF80EF};
        vt[14] = '{1'b1, 1'b0, 9'h010, 3'b011, 32'h00000000, 1'b1, 32'h00000000};
        vt[15] = '{1'b0, 1'b1, 9'h010, 3'b100, 32'h00000000, 1'b1, 32'h00000000};
        vt[16] = '{1'b1, 1'b0, 9'h011, 3'b001, 32'h00000000, 1'b1, 32'h00000000};
        vt[17] = '{1'b1, 1'b0, 9'h010, 3'b000, 32'h00000000, 1'b0, 32'hFFFFFFEF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_err", 32'(bus.err), 32'd0);
        chk("reset_rd_data", bus.rd_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

        // Directed vectors
        for (int i = 0; i < 18; i++) begin
            access(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].f3, vt[i].wd, e, v, lat);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d_rd", i), v, vt[i].exp_rd);
            chk($sformatf("vec%0d_lat", i), lat, 32'd3);
        end

        // Request with neither op: ignored
        @(negedge clk);
        bus.req_valid = 1'b1; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("noop_busy", 32'(bus.busy), 32'd0);
            chk("noop_ready", 32'(bus.req_ready), 32'd1);
        end
        bus.req_valid = 1'b0;
        $display("txn noop request held 4 cycles");

        // Back-to-back loads with req_valid held
        @(negedge clk);
        bus.req_valid = 1'b1; bus.MemRead = 1'b1; bus.MemWrite = 1'b0;
        bus.addr = 9'h010; bus.func3 = 3'b010;
        for (int i = 0; i < 14; i++) begin
            if (bus.req_ready) acc_q.push_back(cyc);
            if (bus.rsp_valid) begin
                rsp_q.push_back(cyc);
                dat_q.push_back(bus.rd_data);
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        if (acc_q.size() >= 2 && rsp_q.size() >= 2) begin
            chk("b2b_second_accept", acc_q[1], rsp_q[0] + 1);
            chk("b2b_rsp_spacing", rsp_q[1] - rsp_q[0], 32'd4);
            chk("b2b_data0", dat_q[0], 32'hBEEF80EF);
            chk("b2b_data1", dat_q[1], 32'hBEEF80EF);
        end else begin
            timeout("b2b_events");
        end
        $display("txn back-to-back LW: accepts=%0d rsps=%0d", acc_q.size(), rsp_q.size());
        for (int i = 0; i < 10 && bus.busy; i++) @(negedge clk);
        acc_q.delete(); rsp_q.delete(); dat_q.delete();

        // Reset during WAIT aborts the store
        access(1'b0, 1'b1, 9'h020, 3'b010, 32'h00000000, e, v, lat);
        chk("abort_pre_err", 32'(e), 32'd0);
        issue(1'b0, 1'b1, 9'h020, 3'b010, 32'h12345678);
        @(negedge clk);
        chk("abort_wait1_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("abort_wait2_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_ready_in_reset", 32'(bus.req_ready), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", 32'(bus.req_ready), 32'd1);
        chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        $display("txn reset pulse during WAIT of SW 020");
        access(1'b1, 1'b0, 9'h020, 3'b010, 32'h0, e, v, lat);
        chk("abort_mem_kept", v, 32'h00000000);

        // Zero-wait-state instance
        @(negedge clk);
        bus0.req_valid = 1'b1; bus0.MemRead = 1'b0; bus0.MemWrite = 1'b1;
        bus0.addr = 9'h040; bus0.func3 = 3'b010; bus0.wr_data = 32'hCAFEF00D;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        chk("w0_store_rsp", 32'(bus0.rsp_valid), 32'd1);
        chk("w0_store_err", 32'(bus0.err), 32'd0);
        @(negedge clk);
        bus0.req_valid = 1'b1; bus0.MemRead = 1'b1; bus0.MemWrite = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus0.req_ready) acc_q.push_back(cyc);
            if (bus0.rsp_valid) begin
                rsp_q.push_back(cyc);
                dat_q.push_back(bus0.rd_data);
            end
            @(negedge clk);
        end
        bus0.req_valid = 1'b0;
        if (acc_q.size() >= 2 && rsp_q.size() >= 1) begin
            chk("w0_latency", rsp_q[0] - acc_q[0], 32'd1);
            chk("w0_accept_spacing", acc_q[1] - acc_q[0], 32'd2);
            chk("w0_data", dat_q[0], 32'hCAFEF00D);
        end else begin
            timeout("w0_events");
        end
        $display("txn zero-wait LW stream: accepts=%0d rsps=%0d", acc_q.size(), rsp_q.size());
        @(negedge clk);

        // Fill memory so the reference model is fully defined
        for (int w = 0; w < 128; w++) begin
            logic [31:0] d;
            d = $urandom;
            model(1'b0, 1'b1, 9'(w * 4), 3'b010, d, me, mv);
            access(1'b0, 1'b1, 9'(w * 4), 3'b010, d, e, v, lat);
            chk("fill_err", 32'(e), 32'(me));
        end

        // Random accesses against the reference model
        for (int i = 0; i < 300; i++) begin
            logic        r, w;
            logic [8:0]  a;
            logic [2:0]  f;
            logic [31:0] d;
            int          k;
            k = $urandom_range(0, 9);
            r = (k == 0) || (k < 5);
            w = (k == 0) || (k >= 5);
            f = 3'($urandom_range(0, 7));
            a = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            d = $urandom;
            model(r, w, a, f, d, me, mv);
            access(r, w, a, f, d, e, v, lat);
            chk($sformatf("rand%0d_err", i), 32'(e), 32'(me));
            chk($sformatf("rand%0d_rd", i), v, mv);
            chk($sformatf("rand%0d_lat", i), lat, 32'd3);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
